// File: rtl/cordic_phase_sequencer.sv
// Front/back end for cordic_sin_cos: folds a full-circle phase into the first quadrant,
// launches the core, then applies quadrant sign/swap correction with a done-timeout.
module cordic_phase_sequencer #(
  parameter int DATA_W  = 16,
  parameter int PI_HALF = 25736,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_phase,
  output logic              cordic_start,
  output logic [DATA_W-1:0] cordic_angle,
  input  logic              cordic_done,
  input  logic [DATA_W-1:0] cordic_cos,
  input  logic [DATA_W-1:0] cordic_sin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_cos,
  output logic [DATA_W-1:0] out_sin,
  output logic              out_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and the payload is held while valid && !ready.

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [14:0]       PI_HALF_W = PI_HALF[14:0];
  localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS  = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        quad_q, quad_d;
  logic [13:0]       frac_q, frac_d;
  logic [DATA_W-1:0] angle_q, angle_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cos_q, cos_d;
  logic [DATA_W-1:0] sin_q, sin_d;
  logic              err_q, err_d;

  logic [28:0]       prod;
  logic [DATA_W-1:0] corr_cos, corr_sin;

  // Two's complement negation that maps the most negative code to the most positive one.
  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    if (x == MOST_NEG) r = MOST_POS;
    else               r = -x;
    return r;
  endfunction

  always_comb begin
    corr_cos = cordic_cos;
    corr_sin = cordic_sin;
    case (quad_q)
      2'd1: begin corr_cos = sat_neg(cordic_sin); corr_sin = cordic_cos;          end
      2'd2: begin corr_cos = sat_neg(cordic_cos); corr_sin = sat_neg(cordic_sin); end
      2'd3: begin corr_cos = cordic_sin;          corr_sin = sat_neg(cordic_cos); end
      default: ;
    endcase
  end

  assign prod = {15'd0, frac_q} * {14'd0, PI_HALF_W};

  always_comb begin
    state_d = state_q;
    quad_d  = quad_q;
    frac_d  = frac_q;
    angle_d = angle_q;
    cnt_d   = cnt_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          quad_d  = in_phase[15:14];
          frac_d  = in_phase[13:0];
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        angle_d = {{(DATA_W-15){1'b0}}, prod[28:14]};
        state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last counted cycle still produces a real result.
        if (cordic_done) begin
          cos_d   = corr_cos;
          sin_d   = corr_sin;
          err_d   = 1'b0;
          state_d = S_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cos_d   = '0;
          sin_d   = '0;
          err_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      quad_q  <= '0;
      frac_q  <= '0;
      angle_q <= '0;
      cnt_q   <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quad_q  <= quad_d;
      frac_q  <= frac_d;
      angle_q <= angle_d;
      cnt_q   <= cnt_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      err_q   <= err_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign cordic_start = (state_q == S_START);
  assign out_valid    = (state_q == S_OUT);
  assign cordic_angle = angle_q;
  assign out_cos      = cos_q;
  assign out_sin      = sin_q;
  assign out_err      = err_q;

endmodule

// File: doc/cordic_phase_sequencer.md
Name: cordic_phase_sequencer

Overview:
Upstream/downstream companion stage for cordic_sin_cos. It accepts full-circle phase words over a valid/ready handshake and folds each phase into the first-quadrant angle the CORDIC core converges on. It then drives the core's start/angle/done interface and applies quadrant sign/swap correction to the returned cos/sin. Corrected results go out on a valid/ready handshake, with a timeout error if the core never signals done.

Parameters:
DATA_W, 16, width of angle and cos/sin words (Q1.14 / Q2.14 two's complement, FRAC=14)
PI_HALF, 25736, pi/2 in Q2.14 (round(1.570796*16384))
TIMEOUT, 64, max cycles in WAIT before error; counter width clog2(TIMEOUT+1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  phase word available
in_ready  out  1  high only in IDLE
in_phase  in  16  unsigned; 0..65535 = 0..2pi; [15:14] quadrant, [13:0] fraction
cordic_start  out  1  one-cycle start pulse to cordic_sin_cos
cordic_angle  out  16  signed Q2.14 angle in [0, pi/2), registered
cordic_done  in  1  done from cordic_sin_cos
cordic_cos  in  16  signed Q1.14
cordic_sin  in  16  signed Q1.14
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_cos  out  16  signed Q1.14 corrected cos
out_sin  out  16  signed Q1.14 corrected sin
out_err  out  1  result is a timeout (cos/sin forced 0)

Behaviour:
- Reset (sync, any state): state=IDLE; in_ready=1, out_valid=0, cordic_start=0, cordic_angle=0, out_cos=0, out_sin=0, out_err=0, timeout counter=0. Reset mid-transaction discards it; no output.
- States: IDLE, CALC, START, WAIT, OUT. All outputs registered or decoded from state only.
- IDLE: in_ready=1. Accept on edge with in_valid=1: latch quad=in_phase[15:14], frac=in_phase[13:0]; go CALC.
- CALC (1 cycle): cordic_angle <= (frac * PI_HALF) >> 14, truncating; unsigned 14x15 product, result 0..25734. Go START.
- START (1 cycle): cordic_start=1 for exactly this cycle; cordic_angle is already stable and is held until the next CALC. Clear counter; go WAIT.
- WAIT: cordic_start=0. If cordic_done=1, register corrected results, out_err=0, go OUT. Else increment counter; when counter reaches TIMEOUT-1 without done, set out_cos=out_sin=0, out_err=1, go OUT. Done and timeout on the same edge: done wins.
- Quadrant correction (C=cordic_cos, S=cordic_sin):
  - q0: (C, S)
  - q1: (-S, C)
  - q2: (-C, -S)
  - q3: (S, -C)
- Negation saturates: -(-32768) = 32767.
- OUT: out_valid=1; out_cos/out_sin/out_err stable while out_valid=1 && out_ready=0. On out_ready=1, go IDLE next edge (out_valid=0). No same-cycle re-accept; in_ready rises the cycle after the output handshake.
- cordic_done outside WAIT is ignored. A done on the same edge as entering WAIT is not sampled; it is seen from the first WAIT cycle.
- Latency, input handshake edge to out_valid=1: 3 cycles + D, where D = cycles from cordic_start to cordic_done (D>=1).
- Throughput: one transaction per 4+D cycles at best.

Test Plan:
1. Phase 0x2000 (45 deg), model returns C=11585,S=11585 after 16 cycles -> cordic_angle=12868, one start pulse, out_cos=11585, out_sin=11585, out_err=0, out_valid 19 cycles after accept.
2. Quadrants: phases 0x0000/0x4000/0x8000/0xC000, model C=16384,S=0 -> angle 0 each; outputs (16384,0), (0,16384), (-16384,0), (0,-16384).
3. Saturation/fraction edge: phase 0x7FFF, model C=-32768,S=100 -> angle 25734, q1: out_cos=-100, out_sin=-32768; phase 0xBFFF, model C=-32768,S=-32768 -> out_cos=32767, out_sin=32767.
4. Timeout: model never asserts done, TIMEOUT=64 -> out_valid with out_err=1, cos=sin=0 after 64 WAIT cycles. Done on the 64th WAIT cycle -> normal result, out_err=0.
5. Backpressure/handshake: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, second in_valid not accepted. Spurious cordic_done in IDLE -> no out_valid.
6. Reset in WAIT and in OUT -> next cycle all outputs at reset values, in_ready=1. A fresh phase 0x2000 then completes exactly as in scenario 1.
